// File: rtl/mbist_march_engine_if.sv
// rtl/mbist_march_engine_if.sv - single-port RAM bus between the March BIST engine and the RAM under test
interface mbist_march_engine_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, mem_we, mem_re, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, mem_we, mem_re, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mbist_march_engine.sv
// rtl/mbist_march_engine.sv - March A4 / March C- memory BIST engine with in-line read compare
module mbist_march_engine #(
  parameter int         ADDR_W = 4,
  parameter int         DATA_W = 8,
  parameter logic [7:0] BG     = 8'h00,
  parameter int         ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               alg_sel,
  mbist_march_engine_if.master mem,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam logic [DATA_W-1:0] BG_D = DATA_W'(BG);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // One March element: last-of-algorithm, direction, two ops?, then (read, value) for op0 and op1.
  typedef struct packed {
    logic last;
    logic down;
    logic two;
    logic rd0;
    logic v0;
    logic rd1;
    logic v1;
  } elem_t;

  function automatic elem_t elem_info(input logic alg, input logic [2:0] e);
    logic [6:0] bits;
    bits = 7'b0;
    if (!alg) begin
      case (e)
        3'd1:    bits = 7'b0_1_0_1_0_0_0;
        3'd2:    bits = 7'b0_0_0_0_1_0_0;
        3'd3:    bits = 7'b1_0_0_1_1_0_0;
        default: bits = 7'b0_0_0_0_0_0_0;
      endcase
    end else begin
      case (e)
        3'd1:    bits = 7'b0_0_1_1_0_0_1;
        3'd2:    bits = 7'b0_0_1_1_1_0_0;
        3'd3:    bits = 7'b0_1_1_1_0_0_1;
        3'd4:    bits = 7'b0_1_1_1_1_0_0;
        3'd5:    bits = 7'b1_0_0_1_0_0_0;
        default: bits = 7'b0_0_0_0_0_0_0;
      endcase
    end
    return elem_t'(bits);
  endfunction

  state_t             state_q, state_d;
  logic               alg_q;
  logic [2:0]         elem_q;
  logic               op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               cmp_valid;
  logic [DATA_W-1:0]  exp_data;
  logic [ADDR_W-1:0]  exp_addr;
  logic               we, re;
  logic [DATA_W-1:0]  wdata;

  elem_t cur, nxt, first;
  logic  op_rd, op_val, last_op, last_addr, end_of_run;
  logic [DATA_W-1:0] op_data;

  assign cur        = elem_info(alg_q, elem_q);
  assign nxt        = elem_info(alg_q, elem_q + 3'd1);
  assign first      = elem_info(alg_sel, 3'd0);
  assign op_rd      = op_q ? cur.rd1 : cur.rd0;
  assign op_val     = op_q ? cur.v1  : cur.v0;
  assign op_data    = op_val ? ~BG_D : BG_D;
  assign last_op    = !cur.two || op_q;
  assign last_addr  = cur.down ? (addr_q == '0) : (addr_q == {ADDR_W{1'b1}});
  assign end_of_run = last_op && last_addr && cur.last;

  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = we;
  assign mem.mem_re    = re;
  assign mem.mem_wdata = wdata;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = '0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        we    = !op_rd;
        re    = op_rd;
        wdata = op_rd ? '0 : op_data;
        if (end_of_run) state_d = FLUSH;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alg_q     <= 1'b0;
      elem_q    <= '0;
      op_q      <= 1'b0;
      addr_q    <= '0;
      cmp_valid <= 1'b0;
      exp_data  <= '0;
      exp_addr  <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      err_cnt   <= '0;
    end else begin
      cmp_valid <= re;
      exp_data  <= op_data;
      exp_addr  <= addr_q;
      case (state_q)
        IDLE: if (start) begin
          alg_q     <= alg_sel;
          elem_q    <= '0;
          op_q      <= 1'b0;
          addr_q    <= first.down ? {ADDR_W{1'b1}} : '0;
          done      <= 1'b0;
          fail      <= 1'b0;
          fail_addr <= '0;
          err_cnt   <= '0;
        end
        RUN: begin
          if (!last_op) begin
            op_q <= 1'b1;
          end else begin
            op_q <= 1'b0;
            if (!last_addr)
              addr_q <= cur.down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
            else if (!cur.last) begin
              elem_q <= elem_q + 3'd1;
              addr_q <= nxt.down ? {ADDR_W{1'b1}} : '0;
            end
          end
        end
        FLUSH: done <= 1'b1;
        default: ;
      endcase
      // Compare slot never overlaps an accepted start: FLUSH issues no read.
      if (cmp_valid && (mem.mem_rdata != exp_data)) begin
        fail <= 1'b1;
        if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
        if (!fail && err_cnt == '0) fail_addr <= exp_addr;
      end
    end
  end

endmodule
